fc_classify: RTL and testbench

FC_CLASSIFY -- requirements
Module: fc_classify

---
 rtl/fc_pkg.sv | 24 ++
 rtl/fc_mac.sv | 35 +++
 rtl/fc_classify.sv | 155 +++++++++++++++
 tb/tb_fc_classify.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared types and constants for the fully-connected classifier.
//   fc_state_t   : controller state encoding
//   weight_t     : one 4-bit signed weight
//   weight_arr_t : flat class-major weight store, index = class*NUM_TAPS + tap
package fc_pkg;

    localparam int NUM_TAPS = 5;
    localparam int NUM_CLS  = 3;
    localparam int DATA_W   = 4;
    localparam int ACC_W    = 10;
    localparam int PROD_W   = 8;
    localparam int NUM_W    = NUM_CLS * NUM_TAPS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_CMP  = 2'd2,
        ST_OUT  = 2'd3
    } fc_state_t;

    typedef logic signed [DATA_W-1:0] weight_t;
    typedef weight_t [NUM_W-1:0]      weight_arr_t;

endpackage

// File: rtl/fc_mac.sv
// fc_mac: one class lane of the classifier, a signed multiply-accumulate.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : acc <= sample*weight (first sample of a frame)
//   acc_en     : acc <= acc + sample*weight
//   sample     : 4-bit signed pooled sample
//   weight     : 4-bit signed weight for the current tap
//   acc        : 10-bit signed accumulator
module fc_mac
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [PROD_W-1:0] prod;

    // Widen before multiplying so the full 8-bit product is kept.
    assign prod = PROD_W'(sample) * PROD_W'(weight);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'(prod);
        end else if (acc_en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fc_classify.sv
// fc_classify: 3-class x 5-tap fully-connected classifier with argmax output.
//   clk, rst_n : clock, synchronous active-low reset
//   in_valid   : pooled-sample strobe
//   in         : 4-bit signed pooled sample
//   w_valid    : weight-load strobe (honoured only in IDLE)
//   w          : 4-bit signed weight, loaded class-major at a wrapping index
//   out_valid  : one-cycle result strobe
//   out        : winning class index, 0 when out_valid=0
//   score      : winning accumulator, 0 when out_valid=0
//                (only with FC_CLASSIFY_SCORE_OUT_EN defined)
//
// state | meaning
// IDLE  | wait for first sample; weight loads accepted
// ACC   | accumulate samples for taps 1..4
// CMP   | register argmax of the three accumulators
// OUT   | present the result for one cycle
module fc_classify
    import fc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in,
    input  logic                     w_valid,
    input  logic signed [DATA_W-1:0] w,
    output logic                     out_valid,
    output logic [1:0]               out
`ifdef FC_CLASSIFY_SCORE_OUT_EN
    ,
    output logic signed [ACC_W-1:0]  score
`endif
);

    fc_state_t                 state;
    weight_arr_t               w_arr;
    logic [3:0]                k;
    logic [2:0]                tap;
    logic [2:0]                tap_sel;
    logic                      mac_load;
    logic                      mac_acc;
    logic signed [DATA_W-1:0]  w_sel [NUM_CLS];
    logic signed [ACC_W-1:0]   acc   [NUM_CLS];
    logic [1:0]                win_idx;
    logic signed [ACC_W-1:0]   win_acc;
    logic [1:0]                win_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_arr <= '0;
            k     <= '0;
        end else if (state == ST_IDLE && w_valid) begin
            w_arr[k] <= w;
            k        <= (k == 4'(NUM_W - 1)) ? 4'd0 : k + 4'd1;
        end
    end

    assign mac_load = (state == ST_IDLE) && in_valid;
    assign mac_acc  = (state == ST_ACC)  && in_valid;

    // The first sample of a frame is taken in IDLE and always uses tap 0.
    always_comb begin
        tap_sel = (state == ST_ACC) ? tap : 3'd0;
        for (int c = 0; c < NUM_CLS; c++) begin
            w_sel[c] = w_arr[4'(c * NUM_TAPS) + 4'(tap_sel)];
        end
    end

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_mac
        fc_mac u_mac (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (mac_load),
            .acc_en (mac_acc),
            .sample (in),
            .weight (w_sel[c]),
            .acc    (acc[c])
        );
    end

    // Strict greater-than: ties keep the lower class index.
    always_comb begin
        win_idx = 2'd0;
        win_acc = acc[0];
        if (acc[1] > win_acc) begin
            win_idx = 2'd1;
            win_acc = acc[1];
        end
        if (acc[2] > win_acc) begin
            win_idx = 2'd2;
            win_acc = acc[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tap       <= '0;
            win_q     <= '0;
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= 1'b0;
            out       <= '0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_ACC;
                        tap   <= 3'd1;
                    end
                end
                ST_ACC: begin
                    // A gap in the burst ends the frame; missing taps add 0.
                    if (in_valid) begin
                        tap <= tap + 3'd1;
                        if (tap == 3'(NUM_TAPS - 1)) begin
                            state <= ST_CMP;
                        end
                    end else begin
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    win_q <= win_idx;
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    out_valid <= 1'b1;
                    out       <= win_q;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FC_CLASSIFY_SCORE_OUT_EN
    logic signed [ACC_W-1:0] win_score_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_score_q <= '0;
            score       <= '0;
        end else begin
            score <= '0;
            if (state == ST_CMP) begin
                win_score_q <= win_acc;
            end
            if (state == ST_OUT) begin
                score <= win_score_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc_classify.sv
module tb_fc_classify;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic signed [3:0] in;
    logic              w_valid;
    logic signed [3:0] w;
    logic              out_valid;
    logic [1:0]        out;
`ifdef FC_CLASSIFY_SCORE_OUT_EN
    logic signed [9:0] score;
`endif

    fc_classify dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (in),
        .w_valid   (w_valid),
        .w         (w),
        .out_valid (out_valid),
        .out       (out)
`ifdef FC_CLASSIFY_SCORE_OUT_EN
        ,
        .score     (score)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Reference model: weight table and load pointer, plus expected results.
    int wm [15];
    int km;
    typedef struct {
        int cls;
        int scr;
        int at;
    } exp_t;
    exp_t q[$];
    int fs [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) wm[i] = 0;
        km = 0;
    endtask

    task automatic load_w(input int v);
        w_valid = 1'b1;
        w       = 4'(v);
        step();
        w_valid = 1'b0;
        wm[km]  = v;
        km      = (km + 1) % 15;
    endtask

    task automatic load_class(input int v0, input int v1, input int v2);
        for (int i = 0; i < 5; i++) load_w(v0);
        for (int i = 0; i < 5; i++) load_w(v1);
        for (int i = 0; i < 5; i++) load_w(v2);
    endtask

    // Frame of n samples from fs[]. The frame ends on the edge that takes the
    // 5th sample, or on the first gap edge for a short burst; the result is
    // due two edges after that.
    task automatic run_frame(input int n, input int extra, input bit wpulse);
        int a [3];
        int best;
        int endc;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in       = 4'(fs[i]);
            w_valid  = wpulse && (i >= 1);
            w        = 4'($urandom_range(15, 0));
            step();
        end
        w_valid = 1'b0;
        if (n < 5) begin
            in_valid = 1'b0;
            step();
        end
        endc = cyc;
        for (int c = 0; c < 3; c++) begin
            a[c] = 0;
            for (int i = 0; i < n; i++) a[c] += fs[i] * wm[c * 5 + i];
        end
        best = 0;
        for (int c = 1; c < 3; c++) if (a[c] > a[best]) best = c;
        e.cls = best;
        e.scr = a[best];
        e.at  = endc + 2;
        q.push_back(e);
        for (int i = 0; i < extra; i++) begin
            in_valid = 1'b1;
            in       = 4'($urandom_range(15, 0));
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
    endtask

    // Monitor: every cycle, either a queued result is due or outputs are idle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid cyc=%0d out=%0d", cyc, out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (out !== 2'(e.cls) || cyc != e.at) begin
                        failures++;
                        $display("FAIL result out=%0d exp=%0d at_cyc=%0d exp_cyc=%0d",
                                 out, e.cls, cyc, e.at);
                    end
`ifdef FC_CLASSIFY_SCORE_OUT_EN
                    checks++;
                    if (score !== 10'(e.scr)) begin
                        failures++;
                        $display("FAIL score got=%0d exp=%0d", score, e.scr);
                    end
`endif
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0 || out !== 2'd0
`ifdef FC_CLASSIFY_SCORE_OUT_EN
                    || score !== 10'sd0
`endif
                   ) begin
                    failures++;
                    $display("FAIL idle_outputs cyc=%0d out_valid=%b out=%0d", cyc, out_valid, out);
                end
            end
        end
    end

    initial begin
        int n;
        int ex;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in       = '0;
        w_valid  = 1'b0;
        w        = '0;
        model_reset();
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b0 || out !== 2'd0) begin
            failures++;
            $display("FAIL reset_state out_valid=%b out=%0d exp 0/0", out_valid, out);
        end
        rst_n = 1'b1;
        step();

        // All-zero weights: every accumulator ties at 0, class 0 wins.
        load_class(0, 0, 0);
        for (int i = 0; i < 5; i++) fs[i] = int'($urandom_range(15, 0)) - 8;
        run_frame(5, 0, 1'b0);

        // 15 / 30 / -15 -> class 1, score 30.
        load_class(1, 2, -1);
        for (int i = 0; i < 5; i++) fs[i] = i + 1;
        run_frame(5, 0, 1'b0);

        // Accumulator upper bound: 5 * (-8 * -8) = 320 on class 2.
        load_class(0, 0, -8);
        for (int i = 0; i < 5; i++) fs[i] = -8;
        run_frame(5, 0, 1'b0);

        // Short burst 7,7,7 -> 21 / 42 / 63.
        load_class(1, 2, 3);
        for (int i = 0; i < 3; i++) fs[i] = 7;
        run_frame(3, 0, 1'b0);

        // 16 writes: the 16th wraps onto W[0][0]; w_valid during ACC ignored.
        for (int i = 0; i < 15; i++) load_w(int'($urandom_range(15, 0)) - 8);
        load_w(5);
        fs[0] = 1; fs[1] = 0; fs[2] = 0; fs[3] = 0; fs[4] = 0;
        run_frame(5, 0, 1'b1);
        for (int i = 0; i < 5; i++) fs[i] = int'($urandom_range(15, 0)) - 8;
        run_frame(5, 2, 1'b1);

        // Reset after the 2nd sample: frame dropped, weights cleared.
        in_valid = 1'b1; in = 4'sd3; step();
        in_valid = 1'b1; in = 4'sd5; step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        repeat (5) step();
        for (int i = 0; i < 5; i++) fs[i] = int'($urandom_range(7, 1));
        run_frame(5, 0, 1'b0);

        // Randomized frames against the model.
        for (int it = 0; it < 40; it++) begin
            n = int'($urandom_range(16, 0));
            for (int i = 0; i < n; i++) load_w(int'($urandom_range(15, 0)) - 8);
            n  = int'($urandom_range(5, 1));
            ex = (n == 5) ? int'($urandom_range(2, 0)) : 0;
            for (int i = 0; i < 5; i++) fs[i] = int'($urandom_range(15, 0)) - 8;
            run_frame(n, ex, 1'($urandom_range(1, 0)));
        end

        for (int t = 0; t < 20 && q.size() != 0; t++) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL missing_results pending=%0d exp 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
